// File: rtl/vector_sequencer_if.sv
// Command-side and DAC-side signal bundle for vector_sequencer.
// slave = the sequencer; master = the fetcher/DAC environment around it.
interface vector_sequencer_if #(
  parameter int W  = 12,
  parameter int ZW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [W-1:0]  cmd_x;
  logic [W-1:0]  cmd_y;
  logic [ZW-1:0] cmd_z;
  logic [W-1:0]  dac_value;
  logic [1:0]    dac_channel;
  logic          dac_strobe;
  logic          dac_ready;

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_z, dac_ready,
    output cmd_ready, dac_value, dac_channel, dac_strobe
  );

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_z, dac_ready,
    input  cmd_ready, dac_value, dac_channel, dac_strobe
  );
endinterface

// File: rtl/vector_sequencer.sv
// Queued JUMP/DRAW vector sequencer with Bresenham stepping, driving X/Y/Z onto a serial DAC.
// Strobes only while dac_ready=1, never on consecutive cycles; cmd_ready drops when the FIFO is full.
module vector_sequencer #(
  parameter int W      = 12,
  parameter int DEPTH  = 8,
  parameter int SETTLE = 64,
  parameter int ZW     = 8
) (
  input  logic              clk,
  input  logic              reset,
  vector_sequencer_if.slave bus,
  output logic [W-1:0]      pos_x,
  output logic [W-1:0]      pos_y,
  output logic              busy,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SETTLE + 1);
  localparam int EW = W + 2;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_BLANK, S_JX, S_JY, S_SETTLE, S_ZSET, S_STEP, S_PX, S_PY
  } state_t;

  typedef struct packed {
    logic          op;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [ZW-1:0] z;
  } cmd_t;

  cmd_t                 mem_q [DEPTH];
  cmd_t                 head, wr_dat, tgt_q, tgt_d;
  state_t               state_q, state_d;
  logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic [W-1:0]         px_q, px_d, py_q, py_d, z_q, z_d, zval, head_zval;
  logic [W-1:0]         dac_val_q, dac_val_d, adx, ady;
  logic [1:0]           dac_ch_q, dac_ch_d;
  logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic signed [EW:0]   e2;
  logic                 sx_q, sx_d, sy_q, sy_d, hold_q, ovf_q, ovf_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 push, pop, need, strobe, step_x, step_y;

  assign count         = wr_ptr_q - rd_ptr_q;
  assign bus.cmd_ready = count < (AW+1)'(DEPTH);
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign pop           = state_q == S_FETCH;
  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_dat        = {bus.cmd_op, bus.cmd_x, bus.cmd_y, bus.cmd_z};

  // A JUMP's Z target is 0 (blank), a DRAW's is its intensity left-justified.
  assign zval      = tgt_q.op ? W'(tgt_q.z) << (W - ZW) : '0;
  assign head_zval = head.op ? W'(head.z) << (W - ZW) : '0;

  always_comb begin
    case (state_q)
      S_BLANK, S_ZSET:        need = zval != z_q;
      S_JX, S_JY, S_PX, S_PY: need = 1'b1;
      default:                need = 1'b0;
    endcase
  end

  // Gated by dac_ready in the same cycle, so the strobe itself cannot be a flop.
  assign strobe = need & bus.dac_ready & ~hold_q & ~reset;

  assign adx    = (tgt_q.x >= px_q) ? tgt_q.x - px_q : px_q - tgt_q.x;
  assign ady    = (tgt_q.y >= py_q) ? tgt_q.y - py_q : py_q - tgt_q.y;
  assign e2     = $signed({err_q, 1'b0});
  assign step_x = e2 >= $signed({dy_q[EW-1], dy_q});
  assign step_y = e2 <= $signed({dx_q[EW-1], dx_q});

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    px_d      = px_q;
    py_d      = py_q;
    z_d       = z_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    err_d     = err_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    cnt_d     = cnt_q;
    dac_val_d = dac_val_q;
    dac_ch_d  = dac_ch_q;
    wr_ptr_d  = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
    ovf_d     = ovf_q | (bus.cmd_valid & ~bus.cmd_ready);
    case (state_q)
      S_IDLE: if (count != '0) state_d = S_FETCH;
      S_FETCH: begin
        tgt_d     = head;
        dac_ch_d  = 2'd2;
        dac_val_d = head_zval;
        state_d   = head.op ? S_ZSET : S_BLANK;
      end
      S_BLANK: if (!need || strobe) begin
        z_d       = zval;
        dac_ch_d  = 2'd0;
        dac_val_d = tgt_q.x;
        state_d   = S_JX;
      end
      S_JX: if (strobe) begin
        dac_ch_d  = 2'd1;
        dac_val_d = tgt_q.y;
        state_d   = S_JY;
      end
      S_JY: if (strobe) begin
        px_d    = tgt_q.x;
        py_d    = tgt_q.y;
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE - 1)) state_d = S_IDLE;
        else                          cnt_d   = cnt_q + CW'(1);
      end
      S_ZSET: if (!need || strobe) begin
        z_d     = zval;
        dx_d    = $signed({2'b00, adx});
        dy_d    = -$signed({2'b00, ady});
        err_d   = $signed({2'b00, adx}) - $signed({2'b00, ady});
        sx_d    = tgt_q.x < px_q;
        sy_d    = tgt_q.y < py_q;
        state_d = S_STEP;
      end
      S_STEP: begin
        if (px_q == tgt_q.x && py_q == tgt_q.y) begin
          state_d = S_IDLE;
        end else begin
          if (step_x) px_d = sx_q ? px_q - W'(1) : px_q + W'(1);
          if (step_y) py_d = sy_q ? py_q - W'(1) : py_q + W'(1);
          err_d     = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
          dac_ch_d  = 2'd0;
          dac_val_d = px_d;
          state_d   = S_PX;
        end
      end
      S_PX: if (strobe) begin
        dac_ch_d  = 2'd1;
        dac_val_d = py_q;
        state_d   = S_PY;
      end
      S_PY: if (strobe) state_d = S_STEP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tgt_q     <= '0;
      px_q      <= '0;
      py_q      <= '0;
      z_q       <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      err_q     <= '0;
      sx_q      <= 1'b0;
      sy_q      <= 1'b0;
      cnt_q     <= '0;
      dac_val_q <= '0;
      dac_ch_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      hold_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      px_q      <= px_d;
      py_q      <= py_d;
      z_q       <= z_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      err_q     <= err_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      cnt_q     <= cnt_d;
      dac_val_q <= dac_val_d;
      dac_ch_q  <= dac_ch_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      hold_q    <= strobe;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end

  assign bus.dac_value   = dac_val_q;
  assign bus.dac_channel = dac_ch_q;
  assign bus.dac_strobe  = strobe;
  assign pos_x           = px_q;
  assign pos_y           = py_q;
  assign busy            = (state_q != S_IDLE) || (count != '0);
  assign overflow        = ovf_q;
endmodule

// File: tb/tb_vector_sequencer.sv
// Bench for vector_sequencer: directed and random JUMP/DRAW traffic, DAC writes scored against
// an in-bench line-drawing model through an expected-strobe queue.
module tb_vector_sequencer;
  localparam int W = 12, DEPTH = 8, SETTLE = 64, ZW = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] pos_x, pos_y;
  logic         busy, overflow;

  vector_sequencer_if #(.W(W), .ZW(ZW)) bus();

  vector_sequencer #(.W(W), .DEPTH(DEPTH), .SETTLE(SETTLE), .ZW(ZW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int v; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0, n_fail = 0, n_strobes = 0, cyc = 0, last_strobe_cyc = 0;
  int   m_x = 0, m_y = 0, m_z = 0;
  int   rdy_mode = 0;
  bit   prev_strobe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // 0: DAC always ready, 1: random ready, 2: DAC stalled
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.dac_ready = 1'b1;
      1:       bus.dac_ready = ($urandom_range(0, 3) != 0);
      default: bus.dac_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (bus.dac_strobe === 1'b1) begin
      n_strobes++;
      last_strobe_cyc = cyc;
      n_checks++;
      if (bus.dac_ready !== 1'b1 || prev_strobe) begin
        n_fail++;
        $display("FAIL dac_rule: strobe with dac_ready=%b prev_strobe=%b, required ready=1 prev=0",
                 bus.dac_ready, prev_strobe);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got ch%0d=%0d, required no strobe",
                 bus.dac_channel, bus.dac_value);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(bus.dac_channel) != mon_e.ch || int'(bus.dac_value) != mon_e.v) begin
          n_fail++;
          $display("FAIL dac_write: got ch%0d=%0d, required ch%0d=%0d",
                   bus.dac_channel, bus.dac_value, mon_e.ch, mon_e.v);
        end
      end
    end
    prev_strobe = (bus.dac_strobe === 1'b1);
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic void expect_write(input int ch, input int v);
    exp_t e;
    e.ch = ch;
    e.v  = v;
    exp_q.push_back(e);
  endfunction

  // Reference: what the beam should write for each accepted command, in order.
  function automatic void model_cmd(input bit op, input int tx, input int ty, input int tz);
    int zv, dx, dy, sx, sy, err, e2;
    if (!op) begin
      if (m_z != 0) expect_write(2, 0);
      m_z = 0;
      expect_write(0, tx);
      expect_write(1, ty);
      m_x = tx;
      m_y = ty;
    end else begin
      zv = tz * (1 << (W - ZW));
      if (zv != m_z) expect_write(2, zv);
      m_z = zv;
      dx  = (tx > m_x) ? tx - m_x : m_x - tx;
      dy  = (ty > m_y) ? m_y - ty : ty - m_y;
      sx  = (tx > m_x) ? 1 : -1;
      sy  = (ty > m_y) ? 1 : -1;
      err = dx + dy;
      while (m_x != tx || m_y != ty) begin
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; m_x += sx; end
        if (e2 <= dx) begin err += dx; m_y += sy; end
        expect_write(0, m_x);
        expect_write(1, m_y);
      end
    end
  endfunction

  // One-cycle command attempt, entered just after a rising edge.
  task automatic issue(input bit op, input int x, input int y, input int z, output bit acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_x     = W'(x);
    bus.cmd_y     = W'(y);
    bus.cmd_z     = ZW'(z);
    @(negedge clk);
    acc = bus.cmd_ready;
    if (acc) model_cmd(op, x, y, z);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send(input bit op, input int x, input int y, input int z);
    int t = 0;
    bit acc;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    issue(op, x, y, z, acc);
    check("send_accepted", int'(acc), 1);
  endtask

  task automatic wait_idle(input string name, output int idle_cyc);
    int t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 40000) begin
      @(negedge clk);
      t++;
    end
    idle_cyc = cyc;
    check({name, "_idle"}, int'(busy !== 1'b0), 0);
    check({name, "_pending"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int s0, ic, n_acc;
    bit acc;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_z     = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_pos_x", int'(pos_x), 0);
    check("rst_pos_y", int'(pos_y), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_strobe", int'(bus.dac_strobe), 0);
    check("rst_dac_value", int'(bus.dac_value), 0);
    check("rst_dac_channel", int'(bus.dac_channel), 0);
    @(posedge clk);
    #1;

    // Jump from reset: no Z write, then X and Y, then the settle window.
    s0 = n_strobes;
    send(0, 100, 200, 0);
    wait_idle("jump", ic);
    check("jump_strobes", n_strobes - s0, 2);
    check("jump_pos_x", int'(pos_x), 100);
    check("jump_pos_y", int'(pos_y), 200);
    check("settle_gap", ic - last_strobe_cyc, SETTLE + 1);

    send(0, 0, 0, 0);
    wait_idle("jump0", ic);
    s0 = n_strobes;
    send(1, 3, 1, 255);
    wait_idle("draw31", ic);
    check("draw31_strobes", n_strobes - s0, 7);
    check("draw31_pos_x", int'(pos_x), 3);
    check("draw31_pos_y", int'(pos_y), 1);

    send(1, 5, 5, 255);
    wait_idle("draw55", ic);
    s0 = n_strobes;
    send(1, 0, 0, 255);
    wait_idle("draw00", ic);
    check("draw00_strobes", n_strobes - s0, 10);
    check("draw00_pos_x", int'(pos_x), 0);

    // Zero-length draws: only a Z write if intensity changes.
    s0 = n_strobes;
    send(1, 0, 0, 128);
    wait_idle("zlen_a", ic);
    check("zlen_new_z_strobes", n_strobes - s0, 1);
    s0 = n_strobes;
    send(1, 0, 0, 128);
    wait_idle("zlen_b", ic);
    check("zlen_same_z_strobes", n_strobes - s0, 0);

    // DAC stall mid-line.
    send(1, 60, 20, 200);
    repeat (30) @(posedge clk);
    #1 rdy_mode = 2;
    @(posedge clk);
    #2 s0 = n_strobes;
    repeat (20) @(posedge clk);
    #2 check("stall_strobes", n_strobes - s0, 0);
    rdy_mode = 0;
    wait_idle("stall_line", ic);
    check("stall_pos_x", int'(pos_x), 60);
    check("stall_pos_y", int'(pos_y), 20);

    // Fill the FIFO behind a stalled jump, then overrun it.
    check("pre_overflow", int'(overflow), 0);
    rdy_mode = 2;
    send(0, 10, 10, 0);
    repeat (5) @(posedge clk);
    #1 n_acc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      issue(1, $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 255), acc);
      n_acc += int'(acc);
    end
    check("fill_accepted", n_acc, DEPTH);
    @(negedge clk);
    check("full_cmd_ready", int'(bus.cmd_ready), 0);
    @(posedge clk);
    #1 issue(0, 1, 1, 0, acc);
    check("overrun_accepted", int'(acc), 0);
    @(negedge clk);
    check("overflow_set", int'(overflow), 1);
    @(posedge clk);
    #1 rdy_mode = 1;
    wait_idle("drain", ic);

    // Random traffic with a jittery DAC.
    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 63),
           ($urandom_range(0, 1) != 0) ? 255 : $urandom_range(0, 255));
    end
    wait_idle("random", ic);
    check("random_pos_x", int'(pos_x), m_x);
    check("random_pos_y", int'(pos_y), m_y);

    // Top-of-range coordinates.
    rdy_mode = 0;
    send(0, 4095, 4095, 0);
    send(1, 4088, 4095, 17);
    send(1, 4095, 4090, 17);
    wait_idle("edge", ic);
    check("edge_pos_x", int'(pos_x), 4095);
    check("edge_pos_y", int'(pos_y), 4090);

    // Reset in the middle of a 100-point line.
    send(1, 3995, 4090, 17);
    repeat (60) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    m_x = 0;
    m_y = 0;
    m_z = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mrst_pos_x", int'(pos_x), 0);
    check("mrst_pos_y", int'(pos_y), 0);
    check("mrst_strobe", int'(bus.dac_strobe), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_cmd_ready", int'(bus.cmd_ready), 1);
    check("mrst_overflow", int'(overflow), 0);
    @(posedge clk);
    #1 send(0, 7, 9, 0);
    wait_idle("post_reset", ic);
    check("post_reset_pos_x", int'(pos_x), 7);
    check("post_reset_pos_y", int'(pos_y), 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
